// File: rtl/cor_sqrt_ctrl_if.sv
// Request/result and CORDIC-core handshake bundle for cor_sqrt_ctrl.
// master: requester plus core model side; slave: the sqrt sequencer.
interface cor_sqrt_ctrl_if #(
   parameter int IO_WIDTH = 18
);
   logic                       start_i;
   logic signed [IO_WIDTH-1:0] operand_i;
   logic                       busy_o;
   logic                       done_o;
   logic signed [IO_WIDTH-1:0] root_o;
   logic                       err_o;
   logic                       cor_start_o;
   logic signed [IO_WIDTH-1:0] cor_x_o;
   logic signed [IO_WIDTH-1:0] cor_y_o;
   logic                       cor_done_i;
   logic signed [IO_WIDTH-1:0] cor_x_i;

   modport master (
      output start_i, operand_i, cor_done_i, cor_x_i,
      input  busy_o, done_o, root_o, err_o, cor_start_o, cor_x_o, cor_y_o
   );

   modport slave (
      input  start_i, operand_i, cor_done_i, cor_x_i,
      output busy_o, done_o, root_o, err_o, cor_start_o, cor_x_o, cor_y_o
   );
endinterface

// File: rtl/cor_sqrt_ctrl.sv
// Square-root sequencer: normalise by powers of four, run a hyperbolic vectoring CORDIC, denormalise.
// Build option COR_SQRT_ROUND_EN: round half-up on the down-scaling (s < 0) denormalisation shift.
module cor_sqrt_ctrl #(
   parameter int IO_WIDTH  = 18,
   parameter int FRAC_BITS = 10
) (
   input  logic           sys_clk_i,
   input  logic           reset_i,
   cor_sqrt_ctrl_if.slave bus
);
   localparam int SHW   = 4;
   localparam int MAX_L = 7;
   localparam int MAX_R = 8;

   localparam logic signed [IO_WIDTH-1:0] HI_LIM  = IO_WIDTH'(2 ** (FRAC_BITS + 1));
   localparam logic signed [IO_WIDTH-1:0] LO_LIM  = IO_WIDTH'(2 ** (FRAC_BITS - 1));
   localparam logic signed [IO_WIDTH-1:0] QUARTER = IO_WIDTH'(2 ** (FRAC_BITS - 2));
   localparam logic signed [IO_WIDTH-1:0] MAX_POS = {1'b0, {(IO_WIDTH-1){1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_NORM,
      S_ISSUE,
      S_WAIT,
      S_DENORM,
      S_DONE
   } state_t;

   state_t                     state_reg, state_next;
   logic signed [IO_WIDTH-1:0] a_reg, a_next;
   logic signed [SHW-1:0]      s_reg, s_next;
   logic signed [IO_WIDTH-1:0] r_reg, r_next;
   logic signed [IO_WIDTH-1:0] root_reg, root_next;
   logic                       err_reg, err_next;
   logic                       done_reg, done_next;
   logic                       busy_reg, busy_next;
   logic                       cor_start_reg, cor_start_next;
   logic signed [IO_WIDTH-1:0] cor_x_reg, cor_x_next;
   logic signed [IO_WIDTH-1:0] cor_y_reg, cor_y_next;

   logic signed [IO_WIDTH-1:0] shl_val [0:MAX_L];
   logic signed [IO_WIDTH-1:0] shr_val [1:MAX_R];
   logic        [SHW-1:0]      neg_s;

   // Every candidate shift is formed in parallel and selected by s in DENORM.
   genvar gi;
   generate
      for (gi = 0; gi <= MAX_L; gi++) begin : g_shl
         logic [IO_WIDTH+MAX_L-1:0] wide;
         assign wide        = {{MAX_L{1'b0}}, r_reg} << gi;
         assign shl_val[gi] = (|wide[IO_WIDTH+MAX_L-1:IO_WIDTH-1]) ? MAX_POS
                                                                    : wide[IO_WIDTH-1:0];
      end

      for (gi = 1; gi <= MAX_R; gi++) begin : g_shr
`ifdef COR_SQRT_ROUND_EN
         logic signed [IO_WIDTH:0] biased;
         logic signed [IO_WIDTH:0] shifted;
         assign biased      = {r_reg[IO_WIDTH-1], r_reg} + (IO_WIDTH+1)'(2 ** (gi - 1));
         assign shifted     = biased >>> gi;
         assign shr_val[gi] = (shifted[IO_WIDTH] != shifted[IO_WIDTH-1]) ? MAX_POS
                                                                          : shifted[IO_WIDTH-1:0];
`else
         assign shr_val[gi] = r_reg >>> gi;
`endif
      end
   endgenerate

   assign neg_s = SHW'(-s_reg);

   always_ff @(posedge sys_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_reg     <= S_IDLE;
         a_reg         <= '0;
         s_reg         <= '0;
         r_reg         <= '0;
         root_reg      <= '0;
         err_reg       <= 1'b0;
         done_reg      <= 1'b0;
         busy_reg      <= 1'b0;
         cor_start_reg <= 1'b0;
         cor_x_reg     <= '0;
         cor_y_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         a_reg         <= a_next;
         s_reg         <= s_next;
         r_reg         <= r_next;
         root_reg      <= root_next;
         err_reg       <= err_next;
         done_reg      <= done_next;
         busy_reg      <= busy_next;
         cor_start_reg <= cor_start_next;
         cor_x_reg     <= cor_x_next;
         cor_y_reg     <= cor_y_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      s_next     = s_reg;
      r_next     = r_reg;
      root_next  = root_reg;
      err_next   = err_reg;
      cor_x_next = cor_x_reg;
      cor_y_next = cor_y_reg;

      case (state_reg)
         S_IDLE: begin
            if (bus.start_i) begin
               a_next     = bus.operand_i;
               s_next     = '0;
               state_next = S_NORM;
            end
         end
         S_NORM: begin
            if (a_reg[IO_WIDTH-1]) begin
               err_next   = 1'b1;
               root_next  = '0;
               state_next = S_DONE;
            end else if (a_reg == '0) begin
               err_next   = 1'b0;
               root_next  = '0;
               state_next = S_DONE;
            end else if (a_reg >= HI_LIM) begin
               a_next = a_reg >>> 2;
               s_next = s_reg + 4'sd1;
            end else if (a_reg < LO_LIM) begin
               a_next = a_reg <<< 2;
               s_next = s_reg - 4'sd1;
            end else begin
               // x^2 - y^2 = a, so the compensated core x result is sqrt(a).
               cor_x_next = a_reg + QUARTER;
               cor_y_next = a_reg - QUARTER;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_next = S_WAIT;
         end
         S_WAIT: begin
            if (bus.cor_done_i) begin
               r_next     = bus.cor_x_i;
               state_next = S_DENORM;
            end
         end
         S_DENORM: begin
            err_next   = 1'b0;
            state_next = S_DONE;
            if (r_reg[IO_WIDTH-1]) begin
               root_next = '0;
            end else if (!s_reg[SHW-1]) begin
               root_next = shl_val[s_reg[SHW-2:0]];
            end else begin
               root_next = shr_val[neg_s];
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      done_next      = (state_next == S_DONE);
      cor_start_next = (state_next == S_ISSUE);
      busy_next      = (state_next == S_NORM) || (state_next == S_ISSUE) ||
                       (state_next == S_WAIT) || (state_next == S_DENORM);
   end

   assign bus.busy_o      = busy_reg;
   assign bus.done_o      = done_reg;
   assign bus.root_o      = root_reg;
   assign bus.err_o       = err_reg;
   assign bus.cor_start_o = cor_start_reg;
   assign bus.cor_x_o     = cor_x_reg;
   assign bus.cor_y_o     = cor_y_reg;
endmodule

// File: tb/tb_cor_sqrt_ctrl.sv
// Directed bench for cor_sqrt_ctrl with a behavioural ideal-sqrt CORDIC core (Lcore = 20).
// Latencies are counted in clock edges from the edge that launches start_i.
module tb_cor_sqrt_ctrl;
   localparam int IO_WIDTH  = 18;
   localparam int FRAC_BITS = 10;
   localparam int LCORE     = 20;
   localparam int TMO       = 200;
   localparam int SAT       = 131071;
`ifdef COR_SQRT_ROUND_EN
   localparam int EXP_RND = 513;
`else
   localparam int EXP_RND = 512;
`endif

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;

   int checks     = 0;
   int failures   = 0;
   int cor_starts = 0;
   int last_x     = 0;
   int last_y     = 0;
   bit force_en   = 1'b0;
   int force_val  = 0;

   cor_sqrt_ctrl_if #(.IO_WIDTH(IO_WIDTH)) bus ();

   cor_sqrt_ctrl #(
      .IO_WIDTH (IO_WIDTH),
      .FRAC_BITS(FRAC_BITS)
   ) dut (
      .sys_clk_i(sys_clk),
      .reset_i  (rst),
      .bus      (bus.slave)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic int isqrt(input longint v);
      int r;
      r = 0;
      if (v <= 0) return 0;
      while (longint'(r + 1) * longint'(r + 1) <= v) r++;
      return r;
   endfunction

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Core model: sees cor_start_o, raises cor_done_i LCORE cycles after the edge that sampled it.
   initial begin
      bus.cor_done_i = 1'b0;
      bus.cor_x_i    = '0;
      forever begin
         @(negedge sys_clk);
         if (bus.cor_start_o === 1'b1) begin
            cor_starts++;
            last_x = int'(bus.cor_x_o);
            last_y = int'(bus.cor_y_o);
            repeat (LCORE + 1) @(posedge sys_clk);
            #1;
            bus.cor_x_i = force_en ? 18'(force_val)
                                   : 18'(isqrt(longint'(last_x) * last_x - longint'(last_y) * last_y));
            bus.cor_done_i = 1'b1;
            @(posedge sys_clk);
            #1;
            bus.cor_done_i = 1'b0;
         end
      end
   end

   task automatic do_case(input string tag, input int opnd, input int exp_root, input int exp_err,
                          input int exp_lat, input bit uses_core, input int exp_x, input int exp_y);
      int lat;
      int cs0;
      cs0 = cor_starts;
      @(posedge sys_clk);
      #1;
      bus.operand_i = 18'(opnd);
      bus.start_i   = 1'b1;
      @(posedge sys_clk);
      #1;
      bus.start_i = 1'b0;
      lat = 1;
      check({tag, "_busy"}, bus.busy_o, 1);
      while (bus.done_o !== 1'b1 && lat < TMO) begin
         @(posedge sys_clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_root"}, bus.root_o, exp_root);
      check({tag, "_err"}, bus.err_o, exp_err);
      check({tag, "_busy_at_done"}, bus.busy_o, 0);
      check({tag, "_cor_starts"}, cor_starts - cs0, uses_core ? 1 : 0);
      if (uses_core) begin
         check({tag, "_cor_x"}, last_x, exp_x);
         check({tag, "_cor_y"}, last_y, exp_y);
      end
      $display("txn %s operand=%0d root=%0d err=%0d latency=%0d", tag, opnd,
               bus.root_o, bus.err_o, lat);
      @(posedge sys_clk);
      #1;
      check({tag, "_done_pulse"}, bus.done_o, 0);
      check({tag, "_root_held"}, bus.root_o, exp_root);
   endtask

   initial begin
      int lat;
      int cs0;
      int seen;
      bus.start_i   = 1'b0;
      bus.operand_i = '0;
      repeat (3) @(posedge sys_clk);
      #1;
      check("rst_busy", bus.busy_o, 0);
      check("rst_done", bus.done_o, 0);
      check("rst_err", bus.err_o, 0);
      check("rst_cor_start", bus.cor_start_o, 0);
      check("rst_root", bus.root_o, 0);
      check("rst_cor_x", bus.cor_x_o, 0);
      check("rst_cor_y", bus.cor_y_o, 0);
      $display("txn reset released");
      rst = 1'b0;

      do_case("sqrt4", 4096, 2048, 0, 26, 1'b1, 1280, 768);
      do_case("sqrt025", 256, 512, 0, 26, 1'b1, 1280, 768);
      do_case("sqrt1", 1024, 1024, 0, 25, 1'b1, 1280, 768);
      do_case("sqrt2", 2048, 1448, 0, 26, 1'b1, 768, 256);
      do_case("tiny", 1, 32, 0, 30, 1'b1, 1280, 768);
      do_case("sub_half", 511, 723, 0, 26, 1'b1, 2300, 1788);
      do_case("maxop", 131071, 11576, 0, 28, 1'b1, 2303, 1791);
      do_case("neg", -1024, 0, 1, 2, 1'b0, 0, 0);
      do_case("zero", 0, 0, 0, 2, 1'b0, 0, 0);

      force_en  = 1'b1;
      force_val = 1025;
      do_case("round", 256, EXP_RND, 0, 26, 1'b1, 1280, 768);
      force_val = 65535;
      do_case("shl_fit", 4096, 131070, 0, 26, 1'b1, 1280, 768);
      force_val = 65536;
      do_case("shl_sat", 4096, SAT, 0, 26, 1'b1, 1280, 768);
      force_val = -5;
      do_case("core_neg", 256, 0, 0, 26, 1'b1, 1280, 768);
      force_en = 1'b0;

      // Second start with another operand while the first waits on the core.
      cs0 = cor_starts;
      @(posedge sys_clk);
      #1;
      bus.operand_i = 18'(4096);
      bus.start_i   = 1'b1;
      @(posedge sys_clk);
      #1;
      bus.start_i = 1'b0;
      lat = 1;
      repeat (8) begin
         @(posedge sys_clk);
         #1;
         lat++;
      end
      bus.operand_i = 18'(16384);
      bus.start_i   = 1'b1;
      @(posedge sys_clk);
      #1;
      bus.start_i = 1'b0;
      lat++;
      while (bus.done_o !== 1'b1 && lat < TMO) begin
         @(posedge sys_clk);
         #1;
         lat++;
      end
      check("wait_start_lat", lat, 26);
      check("wait_start_root", bus.root_o, 2048);
      check("wait_start_cor_x", last_x, 1280);
      $display("txn wait_start root=%0d latency=%0d", bus.root_o, lat);
      repeat (4) @(posedge sys_clk);
      #1;
      check("wait_start_idle", bus.busy_o, 0);
      check("wait_start_cor_starts", cor_starts - cs0, 1);

      // Reset while waiting on the core; the core's late completion must be ignored.
      @(posedge sys_clk);
      #1;
      bus.operand_i = 18'(4096);
      bus.start_i   = 1'b1;
      @(posedge sys_clk);
      #1;
      bus.start_i = 1'b0;
      repeat (8) @(posedge sys_clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy_o, 0);
      check("midrst_done", bus.done_o, 0);
      check("midrst_err", bus.err_o, 0);
      check("midrst_cor_start", bus.cor_start_o, 0);
      check("midrst_root", bus.root_o, 0);
      check("midrst_cor_x", bus.cor_x_o, 0);
      check("midrst_cor_y", bus.cor_y_o, 0);
      $display("txn reset asserted in WAIT");
      repeat (2) @(posedge sys_clk);
      #1;
      rst  = 1'b0;
      seen = 0;
      repeat (30) begin
         @(posedge sys_clk);
         #1;
         if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen++;
      end
      check("late_done_ignored", seen, 0);
      do_case("after_reset", 256, 512, 0, 26, 1'b1, 1280, 768);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
